// File: rtl/wos_pkg.sv
// Shared constants for the masked 2D WOS filter: default window/image sizing and
// the scan controller state encoding.
package wos_pkg;

  localparam int WOS_K          = 3;
  localparam int WOS_INPUT_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/wos_rc_counter.sv
// Raster row/column counter pair: column wraps at i_w_last, row at i_h_last.
// Terminal-count flags are combinational from the current counter values.
module wos_rc_counter import wos_pkg::*; #(
  parameter int INPUT_SIZE = WOS_INPUT_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_inc,
  input  logic [INPUT_SIZE-1:0] i_w_last,
  input  logic [INPUT_SIZE-1:0] i_h_last,
  output logic [INPUT_SIZE-1:0] o_row,
  output logic [INPUT_SIZE-1:0] o_col,
  output logic                  o_at_eol,
  output logic                  o_at_eof
);

  logic [INPUT_SIZE-1:0] r_row;
  logic [INPUT_SIZE-1:0] r_col;
  logic                  w_at_eol;
  logic                  w_at_eof;

  assign w_at_eol = (r_col == i_w_last);
  assign w_at_eof = w_at_eol && (r_row == i_h_last);

  // Wrapping both counters on the last pixel leaves them at zero for the next frame.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      if (w_at_eof) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_at_eol) begin
        r_row <= r_row + INPUT_SIZE'(1);
        r_col <= '0;
      end else begin
        r_col <= r_col + INPUT_SIZE'(1);
      end
    end
  end

  assign o_row    = r_row;
  assign o_col    = r_col;
  assign o_at_eol = w_at_eol;
  assign o_at_eof = w_at_eof;

endmodule

// File: rtl/wos_scan_ctrl.sv
// Raster-scan controller: latches h/w on start, accepts one pixel per cycle in RUN,
// and tags each accept with sof/eol/eof/win_valid for the KxK window datapath.
module wos_scan_ctrl import wos_pkg::*; #(
  parameter int INPUT_SIZE = WOS_INPUT_SIZE,
  parameter int K          = WOS_K
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INPUT_SIZE-1:0] h,
  input  logic [INPUT_SIZE-1:0] w,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [INPUT_SIZE-1:0] row,
  output logic [INPUT_SIZE-1:0] col,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  win_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [INPUT_SIZE-1:0] LP_K   = INPUT_SIZE'(K);
  localparam logic [INPUT_SIZE-1:0] LP_KM1 = INPUT_SIZE'(K - 1);

  scan_state_t           r_state;
  logic [INPUT_SIZE-1:0] r_h_l;
  logic [INPUT_SIZE-1:0] r_w_l;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_dims_ok;
  logic                  w_start_ok;
  logic [INPUT_SIZE-1:0] w_row;
  logic [INPUT_SIZE-1:0] w_col;
  logic                  w_at_eol;
  logic                  w_at_eof;
  logic [INPUT_SIZE-1:0] w_w_last;
  logic [INPUT_SIZE-1:0] w_h_last;

  assign pix_ready  = (r_state == ST_RUN);
  assign w_accept   = pix_valid && pix_ready;
  assign w_dims_ok  = (h >= LP_K) && (w >= LP_K);
  assign w_start_ok = (r_state == ST_IDLE) && start && w_dims_ok;
  // Shadows are always >= K >= 2 while in RUN, so these never underflow when used.
  assign w_w_last   = r_w_l - INPUT_SIZE'(1);
  assign w_h_last   = r_h_l - INPUT_SIZE'(1);

  wos_rc_counter #(
    .INPUT_SIZE (INPUT_SIZE)
  ) u_rc_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_start_ok),
    .i_inc    (w_accept),
    .i_w_last (w_w_last),
    .i_h_last (w_h_last),
    .o_row    (w_row),
    .o_col    (w_col),
    .o_at_eol (w_at_eol),
    .o_at_eof (w_at_eof)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_h_l   <= '0;
      r_w_l   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_dims_ok) begin
              r_h_l   <= h;
              r_w_l   <= w;
              r_state <= ST_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept && w_at_eof) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign row       = w_row;
  assign col       = w_col;
  assign sof       = w_accept && (w_row == '0) && (w_col == '0);
  assign eol       = w_accept && w_at_eol;
  assign eof       = w_accept && w_at_eof;
  assign win_valid = w_accept && (w_row >= LP_KM1) && (w_col >= LP_KM1);

endmodule

// File: tb/tb_wos_scan_ctrl.sv
// Directed bench for wos_scan_ctrl: frame sweeps against a small raster model,
// bad-dimension starts, mid-frame dimension/start changes and mid-frame reset.
module tb_wos_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] h;
  logic [7:0] w;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] row;
  logic [7:0] col;
  logic       sof;
  logic       eol;
  logic       eof;
  logic       win_valid;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  wos_scan_ctrl #(.INPUT_SIZE(8), .K(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .h         (h),
    .w         (w),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .row       (row),
    .col       (col),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .win_valid (win_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  // mode 0: pix_valid held high; mode 1: pix_valid pattern 1,0,0 repeating.
  task automatic run_frame(input string tag, input int hh, input int ww, input int mode,
                           input int chg_at, input int start_at, input int rst_at,
                           input int e_acc, input int e_eol, input int e_win, input int e_len);
    int acc, er, ec, bad, n_sof, n_eol, n_eof, n_win, cyc, k, budget;
    bit fin, m_eol, m_eof, m_win;
    acc = 0; er = 0; ec = 0; bad = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_win = 0;
    k = 0; fin = 1'b0; budget = hh * ww * 3 + 20;
    @(negedge clk);
    start = 1'b1; h = 8'(hh); w = 8'(ww); pix_valid = 1'b0;
    cyc = 1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      pix_valid = (mode == 0 || (k % 3) == 0) ? 1'b1 : 1'b0;
      k++;
      start = (start_at != 0 && acc + 1 == start_at) ? 1'b1 : 1'b0;
      rst   = (rst_at != 0 && acc + 1 == rst_at) ? 1'b1 : 1'b0;
      if (chg_at != 0 && acc + 1 == chg_at) begin
        h = 8'd7;
        w = 8'd9;
      end
      #1;
      if (k == 1) check({tag, ".ready_after_start"}, 32'(pix_ready), 32'd1);
      if (pix_valid && pix_ready) begin
        acc++;
        m_eol = (ec == ww - 1);
        m_eof = m_eol && (er == hh - 1);
        m_win = (er >= 2) && (ec >= 2);
        if (32'(row) != er || 32'(col) != ec) bad++;
        if (sof != (er == 0 && ec == 0) || eol != m_eol || eof != m_eof || win_valid != m_win) bad++;
        n_sof += int'(sof);
        n_eol += int'(eol);
        n_eof += int'(eof);
        n_win += int'(win_valid);
        if (m_eol) begin
          ec = 0;
          er++;
        end else begin
          ec++;
        end
        if (m_eof || rst) fin = 1'b1;
      end
    end
    check({tag, ".finished_in_budget"}, 32'(fin), 32'd1);
    @(negedge clk);
    start = 1'b0; rst = 1'b0; pix_valid = 1'b0;
    #1;
    cyc++;
    if (rst_at != 0) begin
      check({tag, ".rst_ready"}, 32'(pix_ready), 32'd0);
      check({tag, ".rst_busy"}, 32'(busy), 32'd0);
      check({tag, ".rst_done"}, 32'(done), 32'd0);
      check({tag, ".rst_rowcol"}, {16'd0, row, col}, 32'd0);
      @(negedge clk); #1;
      check({tag, ".rst_no_done"}, 32'(done), 32'd0);
    end else begin
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".done_ready"}, 32'(pix_ready), 32'd0);
      check({tag, ".done_busy"}, 32'(busy), 32'd1);
      check({tag, ".frame_len"}, 32'(cyc), 32'(e_len));
      @(negedge clk); #1;
      check({tag, ".done_pulse_end"}, 32'(done), 32'd0);
      check({tag, ".busy_fall"}, 32'(busy), 32'd0);
    end
    check({tag, ".accepts"}, 32'(acc), 32'(e_acc));
    check({tag, ".per_pixel_bad"}, 32'(bad), 32'd0);
    check({tag, ".sof_cnt"}, 32'(n_sof), 32'd1);
    check({tag, ".eol_cnt"}, 32'(n_eol), 32'(e_eol));
    check({tag, ".eof_cnt"}, 32'(n_eof), (rst_at != 0) ? 32'd0 : 32'd1);
    check({tag, ".win_cnt"}, 32'(n_win), 32'(e_win));
  endtask

  task automatic bad_start(input string tag, input int hh, input int ww);
    @(negedge clk);
    start = 1'b1; h = 8'(hh); w = 8'(ww); pix_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, ".err"}, 32'(err), 32'd1);
    check({tag, ".ready"}, 32'(pix_ready), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    @(negedge clk); #1;
    check({tag, ".err_pulse_end"}, 32'(err), 32'd0);
    check({tag, ".still_idle"}, 32'(busy), 32'd0);
    pix_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; h = 8'd0; w = 8'd0; pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset.ready", 32'(pix_ready), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done_err", {30'd0, done, err}, 32'd0);
    check("reset.rowcol", {16'd0, row, col}, 32'd0);
    check("reset.flags", {28'd0, sof, eol, eof, win_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; pix_valid = 1'b0;

    run_frame("f3x4", 3, 4, 0, 0, 0, 0, 12, 3, 2, 14);
    bad_start("err2x5", 2, 5);
    bad_start("err2x0", 2, 0);
    run_frame("f3x3_stall", 3, 3, 1, 0, 0, 0, 9, 3, 1, 27);
    run_frame("f4x4_chg", 4, 4, 0, 5, 6, 0, 16, 4, 4, 18);
    run_frame("f7x9", 7, 9, 0, 0, 0, 0, 63, 7, 35, 65);
    run_frame("f3x4_rst", 3, 4, 0, 0, 0, 7, 7, 1, 0, 0);
    run_frame("f3x4_after_rst", 3, 4, 0, 0, 0, 0, 12, 3, 2, 14);
    run_frame("f255", 255, 255, 0, 0, 0, 0, 65025, 255, 253 * 253, 65027);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wos_scan_ctrl.md
Name: wos_scan_ctrl

Overview:
- Raster-scan controller directly downstream of the parameter register bank in the masked 2D WOS filter.
- Consumes the stored image height h and width w, accepts one pixel per cycle in raster order, and tracks row/col.
- Tags each accepted pixel with frame/line flags and a window-valid flag for the KxK window datapath and line buffers.
- Start/busy/done handshake to the top-level sequencer.

Parameters:
- INPUT_SIZE, 8, width of h, w and the row/col counters.
- K, 3, window side length; a window is complete when row >= K-1 and col >= K-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE.
- h  in  INPUT_SIZE  image height in rows, from the parameter bank.
- w  in  INPUT_SIZE  image width in columns, from the parameter bank.
- pix_valid  in  1  upstream pixel present.
- pix_ready  out  1  block accepts a pixel; accept = pix_valid & pix_ready.
- row  out  INPUT_SIZE  row index of the pixel being accepted.
- col  out  INPUT_SIZE  column index of the pixel being accepted.
- sof  out  1  accept of pixel (0,0).
- eol  out  1  accept with col == w_l-1.
- eof  out  1  accept of pixel (h_l-1, w_l-1).
- win_valid  out  1  accept with row >= K-1 and col >= K-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, frame complete.
- err  out  1  one-cycle pulse, start rejected because of bad dimensions.

Behaviour:
- Reset, synchronous active-high, takes priority over everything:
  - state=IDLE, row=0, col=0, h_l=0, w_l=0.
  - pix_ready=0, busy=0, done=0, err=0.
  - sof, eol, eof and win_valid are 0 whenever there is no accept.
- Dimension latch:
  - On start in IDLE, h and w are copied into shadow registers h_l and w_l.
  - Later changes on h/w are ignored until the next start.
- States: IDLE, RUN, DONE.
  - IDLE, start=1, h >= K and w >= K -> RUN next cycle; row=col=0.
  - IDLE, start=1, h < K or w < K (includes 0) -> err=1 the next cycle for exactly one cycle; stay IDLE; shadows are not updated.
  - RUN: pix_ready=1 combinationally.
    - On accept with col < w_l-1: col+1.
    - On accept with col == w_l-1: col=0, row+1.
    - On accept of the last pixel (eof): go to DONE.
  - DONE: pix_ready=0, done=1 for exactly one cycle, then IDLE. row/col return to 0.
- Handshake:
  - pix_ready is never asserted outside RUN.
  - Stalls (pix_valid=0) hold all counters; there is no timeout.
- Flags:
  - row/col are the current counter values and are valid only while accept=1.
  - sof, eol, eof and win_valid are combinational from the counters and qualified by accept.
- Latency:
  - start -> pix_ready: 1 cycle.
  - Last accept -> done: 1 cycle.
  - Minimum frame length: h_l*w_l + 2 cycles, measured from start to the done cycle inclusive.
- start while busy: ignored, with no effect on counters or shadows.
- Width rules:
  - Counters are INPUT_SIZE bits; maximum frame is (2^INPUT_SIZE-1)^2.
  - Comparisons use w_l-1 and h_l-1. These never underflow, because h_l and w_l >= K >= 2 is guaranteed by the start check.
- Reset mid-frame: immediate return to IDLE with counters cleared; no done or err pulse.

Decomposition:
- Shared package wos_pkg:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default K and INPUT_SIZE, shared with the parameter bank and window datapath.
- One natural sub-module: wos_rc_counter.
  - Row/column counter pair with wrap at w_l-1.
  - Terminal-count outputs at_eol and at_eof.
- The FSM and flag logic stay in wos_scan_ctrl.

Test Plan:
- h=3, w=4, K=3, start, pix_valid held high.
  - pix_ready rises the cycle after start; 12 accepts occur.
  - eol on accepts 4, 8 and 12; sof on accept 1; eof on accept 12.
  - win_valid on (2,2) and (2,3) only; done one cycle after accept 12; busy falls with done.
- h=2, w=5, start -> err pulses one cycle; pix_ready and busy stay 0. Repeat with w=0 -> same result.
- h=3, w=3, pix_valid toggling 1,0,0,1,...
  - Counters advance only on accepts; exactly 9 accepts.
  - win_valid only on (2,2); done after the 9th accept.
- h=4, w=4: change h to 7 and w to 9 at accept 5, and pulse start at accept 6.
  - Frame still ends after 16 accepts; no restart.
  - A second start afterwards latches 7x9 (63 accepts).
- rst asserted at accept 7 of a 3x4 frame.
  - Next cycle: IDLE, pix_ready=0, row=col=0, no done.
  - A fresh start then runs the full 12 pixels.
- INPUT_SIZE=8, h=w=255.
  - 65025 accepts; last accept at row=254, col=254 with eof=1; no counter overflow.
